// File: rtl/stopwatch_ctrl_pkg.sv
// Shared state encodings, output bundle and decode helpers for the stopwatch controller.
package stopwatch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_RUN   = 3'd2,
        ST_LAP   = 3'd3,
        ST_PAUSE = 3'd4
    } sw_state_t;

    typedef struct packed {
        logic init_regs;
        logic count_en;
        logic lap_active;
    } sw_out_t;

    localparam logic [7:0] BCD_ZERO = 8'h00;

    function automatic logic is_counting(input sw_state_t st);
        return (st == ST_RUN) || (st == ST_LAP);
    endfunction

    // Output values that hold for the whole time the FSM sits in a state.
    function automatic sw_out_t decode_outputs(input sw_state_t st);
        sw_out_t o;
        o.init_regs  = (st == ST_CLEAR);
        o.count_en   = is_counting(st);
        o.lap_active = (st == ST_LAP);
        return o;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_button_conditioner.sv
// Synchronises and debounces one raw push-button into a single-cycle press pulse.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic [CNT_W-1:0] stable_cnt_r;
    logic             pulse_r;

    // Two-flop synchroniser for the asynchronous button level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    // Stable-high counter: saturates so a held button cannot re-trigger
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_cnt_r <= {CNT_W{1'b0}};
        end else if (!sync2_r) begin
            stable_cnt_r <= {CNT_W{1'b0}};
        end else if (stable_cnt_r != CNT_MAX) begin
            stable_cnt_r <= stable_cnt_r + CNT_W'(1);
        end else begin
            stable_cnt_r <= stable_cnt_r;
        end
    end

    // Pulse is registered alongside the counter reaching its limit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_r <= 1'b0;
        end else begin
            pulse_r <= sync2_r && (stable_cnt_r == CNT_ARM);
        end
    end

    assign press_pulse = pulse_r;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Push-button stopwatch sequencer: drives the seconds counter and selects a live or lapped display value.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CLEAR_CYCLES    = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    input  logic       btn_lap,
    input  logic [7:0] time_reading,
    output logic       init_regs,
    output logic       count_enabled,
    output logic [7:0] display_reading,
    output logic       running,
    output logic       lap_active
);

    localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);

    sw_state_t        state_r;
    sw_out_t          out_r;
    logic [CLR_W-1:0] clear_cnt_r;
    logic [7:0]       lap_reg_r;
    logic             ss_pulse_s;
    logic             clr_pulse_s;
    logic             lap_pulse_s;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_start_stop (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_raw     (btn_start_stop),
        .press_pulse (ss_pulse_s)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clear (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_raw     (btn_clear),
        .press_pulse (clr_pulse_s)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_lap (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_raw     (btn_lap),
        .press_pulse (lap_pulse_s)
    );

    // Controller FSM; pulse priority is clear, then start/stop, then lap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_CLEAR;
            clear_cnt_r <= {CLR_W{1'b0}};
            lap_reg_r   <= BCD_ZERO;
            out_r       <= decode_outputs(ST_CLEAR);
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    // Pulses are dropped until the counter has been cleared
                    if (clear_cnt_r == CLR_LAST) begin
                        state_r <= ST_IDLE;
                        out_r   <= decode_outputs(ST_IDLE);
                    end else begin
                        clear_cnt_r <= clear_cnt_r + CLR_W'(1);
                    end
                end
                ST_IDLE, ST_PAUSE: begin
                    if (clr_pulse_s) begin
                        state_r     <= ST_CLEAR;
                        clear_cnt_r <= {CLR_W{1'b0}};
                        lap_reg_r   <= BCD_ZERO;
                        out_r       <= decode_outputs(ST_CLEAR);
                    end else if (ss_pulse_s) begin
                        state_r <= ST_RUN;
                        out_r   <= decode_outputs(ST_RUN);
                    end
                end
                ST_RUN: begin
                    if (clr_pulse_s) begin
                        state_r     <= ST_CLEAR;
                        clear_cnt_r <= {CLR_W{1'b0}};
                        lap_reg_r   <= BCD_ZERO;
                        out_r       <= decode_outputs(ST_CLEAR);
                    end else if (ss_pulse_s) begin
                        state_r <= ST_PAUSE;
                        out_r   <= decode_outputs(ST_PAUSE);
                    end else if (lap_pulse_s) begin
                        state_r   <= ST_LAP;
                        lap_reg_r <= time_reading;
                        out_r     <= decode_outputs(ST_LAP);
                    end
                end
                ST_LAP: begin
                    if (clr_pulse_s) begin
                        state_r     <= ST_CLEAR;
                        clear_cnt_r <= {CLR_W{1'b0}};
                        lap_reg_r   <= BCD_ZERO;
                        out_r       <= decode_outputs(ST_CLEAR);
                    end else if (ss_pulse_s) begin
                        state_r <= ST_PAUSE;
                        out_r   <= decode_outputs(ST_PAUSE);
                    end else if (lap_pulse_s) begin
                        state_r <= ST_RUN;
                        out_r   <= decode_outputs(ST_RUN);
                    end
                end
                default: begin
                    state_r     <= ST_CLEAR;
                    clear_cnt_r <= {CLR_W{1'b0}};
                    lap_reg_r   <= BCD_ZERO;
                    out_r       <= decode_outputs(ST_CLEAR);
                end
            endcase
        end
    end

    assign init_regs       = out_r.init_regs;
    assign count_enabled   = out_r.count_en;
    assign running         = out_r.count_en;
    assign lap_active      = out_r.lap_active;
    assign display_reading = out_r.lap_active ? lap_reg_r : time_reading;

endmodule
